intprod_seq_mac: RTL and testbench

Parametrised, sequential successor to the 5-element inner-product unit used by the matrix multiplier. Computes the signed dot product of one row vector and one column vector of `N` elements of `W` bits, processing `L` element pairs per clock under a start/done handshake. Produces a `W`-bit result with an overflow flag in either wrap or saturate mode. Instantiated per output element, or time-shared, inside the matrix multiply datapath.

---
 rtl/intprod_seq_mac_if.sv | 17 +
 rtl/intprod_seq_mac.sv | 145 ++++++++++++++
 tb/tb_intprod_seq_mac.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/intprod_seq_mac_if.sv
// Operand/result bundle for the sequential inner-product unit.
// The requester (master) drives start and both vectors; the unit (slave) returns status and result.
interface intprod_seq_mac_if #(
  parameter int W = 8,
  parameter int N = 5
);
  logic           start;
  logic [N*W-1:0] lin;
  logic [N*W-1:0] col;
  logic           busy;
  logic           done;
  logic [W-1:0]   n_out;
  logic           ovf;

  modport master (output start, lin, col, input busy, done, n_out, ovf);
  modport slave  (input start, lin, col, output busy, done, n_out, ovf);
endinterface

// File: rtl/intprod_seq_mac.sv
// Sequential signed dot product of two N-element vectors, L multiply-adds per clock.
// The result is resolved to W bits by wrap or saturation, with an overflow flag.
module intprod_seq_mac #(
  parameter int W   = 8,
  parameter int N   = 5,
  parameter int L   = 1,
  parameter int SAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  intprod_seq_mac_if.slave  bus
);
  localparam int BEATS = N / L;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = 2 * W + $clog2(N);
  localparam logic signed [AW-1:0] MAX_V = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  if ((N % L) != 0 || W < 2 || N < 1 || L < 1) begin : g_bad_params
    $error("intprod_seq_mac: N must be a multiple of L, W >= 2, N >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [N*W-1:0]         lin_r;
  logic [N*W-1:0]         col_r;
  logic signed [AW-1:0]   acc_r;
  logic [BW-1:0]          beat_r;
  logic                   busy_r;
  logic                   done_r;
  logic [W-1:0]           n_out_r;
  logic                   ovf_r;
  logic                   busy_nxt_s;
  logic                   done_nxt_s;
  logic                   load_s;
  logic                   last_beat_s;
  logic signed [W-1:0]    a_s;
  logic signed [W-1:0]    b_s;
  logic signed [2*W-1:0]  prod_s;
  logic signed [AW-1:0]   lane_sum_s;
  logic signed [AW-1:0]   sum_s;
  logic [W-1:0]           res_s;
  logic                   ovf_s;

  assign last_beat_s = (beat_r == BW'(BEATS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode; start only matters in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_nxt_s = RUN; else state_nxt_s = IDLE;
      RUN:     if (last_beat_s) state_nxt_s = DONE; else state_nxt_s = RUN;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode; status flags are taken from the next state so they can be registered
  always_comb begin
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_nxt_s == DONE);
    load_s     = (state_r == IDLE) && bus.start;
  end

  // Lane products for the current beat, summed at full precision
  always_comb begin
    a_s        = '0;
    b_s        = '0;
    prod_s     = '0;
    lane_sum_s = '0;
    for (int l = 0; l < L; l++) begin
      a_s        = lin_r[(int'(beat_r) * L + l) * W +: W];
      b_s        = col_r[(int'(beat_r) * L + l) * W +: W];
      prod_s     = (2*W)'(a_s) * (2*W)'(b_s);
      lane_sum_s = lane_sum_s + AW'(prod_s);
    end
    sum_s = acc_r + lane_sum_s;
  end

  // Resolve the exact sum into W bits under the selected overflow policy
  always_comb begin
    ovf_s = (sum_s > MAX_V) || (sum_s < MIN_V);
    if (SAT != 0) begin
      if (sum_s > MAX_V) begin
        res_s = MAX_V[W-1:0];
      end else if (sum_s < MIN_V) begin
        res_s = MIN_V[W-1:0];
      end else begin
        res_s = sum_s[W-1:0];
      end
    end else begin
      res_s = sum_s[W-1:0];
    end
  end

  // Operand capture, accumulation, and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      lin_r   <= '0;
      col_r   <= '0;
      acc_r   <= '0;
      beat_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      n_out_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (load_s) begin
        lin_r  <= bus.lin;
        col_r  <= bus.col;
        acc_r  <= '0;
        beat_r <= '0;
      end else if (state_r == RUN) begin
        acc_r <= sum_s;
        if (last_beat_s) begin
          beat_r  <= '0;
          n_out_r <= res_s;
          ovf_r   <= ovf_s;
        end else begin
          beat_r <= beat_r + BW'(1);
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.n_out = n_out_r;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_intprod_seq_mac.sv
// Scoreboard bench for intprod_seq_mac: wrap, saturate and 5-lane instances share one clock/reset.
// Expected results are queued when an operation is issued and popped by per-instance monitors on done.
module tb_intprod_seq_mac;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] q_n [3][$];
  logic       q_o [3][$];

  always #5 clk = ~clk;

  intprod_seq_mac_if #(.W(8), .N(5)) if0 ();
  intprod_seq_mac_if #(.W(8), .N(5)) if1 ();
  intprod_seq_mac_if #(.W(8), .N(5)) if2 ();

  intprod_seq_mac #(.W(8), .N(5), .L(1), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(if0.slave));
  intprod_seq_mac #(.W(8), .N(5), .L(1), .SAT(1)) u_sat  (.clk(clk), .rst(rst), .bus(if1.slave));
  intprod_seq_mac #(.W(8), .N(5), .L(5), .SAT(0)) u_lane (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int e0, input int e1, input int e2, input int e3, input int e4);
    logic [39:0] v;
    v[7:0]   = 8'(e0);
    v[15:8]  = 8'(e1);
    v[23:16] = 8'(e2);
    v[31:24] = 8'(e3);
    v[39:32] = 8'(e4);
    return v;
  endfunction

  function automatic logic get_done(input int k);
    case (k)
      0: return if0.done;
      1: return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      0: return if0.busy;
      1: return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [10:0] get_outs(input int k);
    case (k)
      0: return {if0.busy, if0.done, if0.ovf, if0.n_out};
      1: return {if1.busy, if1.done, if1.ovf, if1.n_out};
      default: return {if2.busy, if2.done, if2.ovf, if2.n_out};
    endcase
  endfunction

  task automatic drive(input int k, input logic [39:0] l, input logic [39:0] c, input logic s);
    case (k)
      0: begin if0.lin = l; if0.col = c; if0.start = s; end
      1: begin if1.lin = l; if1.col = c; if1.start = s; end
      default: begin if2.lin = l; if2.col = c; if2.start = s; end
    endcase
  endtask

  // One-cycle start pulse; returns at the negedge after the accepting edge
  task automatic issue(input int k, input logic [39:0] l, input logic [39:0] c,
                       input bit push, input logic [7:0] en, input logic eo);
    @(negedge clk);
    drive(k, l, c, 1'b1);
    if (push) begin
      q_n[k].push_back(en);
      q_o[k].push_back(eo);
    end
    @(negedge clk);
    drive(k, 40'h00_0000_0000, 40'h00_0000_0000, 1'b0);
  endtask

  task automatic await_done(input int k, input int lat, input string nm);
    int edges = 0;
    int bcnt  = 0;
    while (!get_done(k) && edges < 40) begin
      if (get_busy(k)) bcnt++;
      @(negedge clk);
      edges++;
    end
    if (get_busy(k)) bcnt++;
    check({nm, "_latency"}, 32'(edges), 32'(lat));
    check({nm, "_busy_cycles"}, 32'(bcnt), 32'(lat + 1));
    @(negedge clk);
    check({nm, "_idle_after"}, {30'd0, get_busy(k), get_done(k)}, 32'd0);
  endtask

  // Scoreboard monitors: one per instance, compare on every done pulse
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      if (get_done(g)) begin
        if (q_n[g].size() == 0) begin
          check($sformatf("dut%0d_unexpected_done", g), 32'd1, 32'd0);
        end else begin
          logic [10:0] o;
          logic [7:0]  en;
          logic        eo;
          o  = get_outs(g);
          en = q_n[g].pop_front();
          eo = q_o[g].pop_front();
          check($sformatf("dut%0d_n_out", g), {24'd0, o[7:0]}, {24'd0, en});
          check($sformatf("dut%0d_ovf", g), {31'd0, o[8]}, {31'd0, eo});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 40'h00_0000_0000, 40'h00_0000_0000, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("reset_outs%0d", k), {21'd0, get_outs(k)}, 32'd0);
    rst = 1'b1;

    // Wrap instance
    issue(0, pk(1, 2, 3, 4, 5), pk(1, 1, 1, 1, 1), 1'b1, 8'd15, 1'b0);
    await_done(0, 5, "wrap_basic");
    issue(0, pk(10, 10, 10, 10, 10), pk(10, 10, 10, 10, 10), 1'b1, 8'hF4, 1'b1);
    await_done(0, 5, "wrap_500");
    issue(0, pk(127, 1, 0, 0, 0), pk(1, 1, 0, 0, 0), 1'b1, 8'h80, 1'b1);
    await_done(0, 5, "wrap_128");

    // Saturating instance, including exact range limits
    issue(1, pk(10, 10, 10, 10, 10), pk(10, 10, 10, 10, 10), 1'b1, 8'h7F, 1'b1);
    await_done(1, 5, "sat_500");
    issue(1, pk(-128, -128, -128, -128, -128), pk(1, 1, 1, 1, 1), 1'b1, 8'h80, 1'b1);
    await_done(1, 5, "sat_m640");
    issue(1, pk(-1, -1, -1, -1, -1), pk(2, 2, 2, 2, 2), 1'b1, 8'hF6, 1'b0);
    await_done(1, 5, "sat_m10");
    issue(1, pk(127, 0, 0, 0, 0), pk(1, 0, 0, 0, 0), 1'b1, 8'h7F, 1'b0);
    await_done(1, 5, "sat_127");
    issue(1, pk(127, 1, 0, 0, 0), pk(1, 1, 0, 0, 0), 1'b1, 8'h7F, 1'b1);
    await_done(1, 5, "sat_128");
    issue(1, pk(-128, 0, 0, 0, 0), pk(1, 0, 0, 0, 0), 1'b1, 8'h80, 1'b0);
    await_done(1, 5, "sat_m128");
    issue(1, pk(-128, -1, 0, 0, 0), pk(1, 1, 0, 0, 0), 1'b1, 8'h80, 1'b1);
    await_done(1, 5, "sat_m129");

    // Five-lane instance finishes one edge after start
    issue(2, pk(1, 2, 3, 4, 5), pk(5, 4, 3, 2, 1), 1'b1, 8'd35, 1'b0);
    await_done(2, 1, "lane_35");
    issue(2, pk(-128, -128, -128, -128, -128), pk(-128, -128, -128, -128, -128), 1'b1, 8'h00, 1'b1);
    await_done(2, 1, "lane_81920");

    // Reset sampled at the third RUN edge aborts without a done
    issue(0, pk(2, -3, 4, 1, 0), pk(3, 3, -1, 5, 7), 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_outs", {21'd0, get_outs(0)}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    issue(0, pk(1, 2, 3, 4, 5), pk(5, 4, 3, 2, 1), 1'b1, 8'd35, 1'b0);
    await_done(0, 5, "after_abort");

    // start held high, operands changed mid-RUN
    @(negedge clk);
    drive(0, pk(2, -3, 4, 1, 0), pk(3, 3, -1, 5, 7), 1'b1);
    q_n[0].push_back(8'hFE); q_o[0].push_back(1'b0);
    q_n[0].push_back(8'h96); q_o[0].push_back(1'b1);
    @(negedge clk);
    @(negedge clk);
    drive(0, pk(10, 10, 10, 10, 10), pk(3, 3, 3, 3, 3), 1'b1);
    t = 0;
    while (!if0.done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("held_first_done_seen", {31'd0, if0.done}, 32'd1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!if0.done && t < 40);
    check("held_done_spacing", 32'(t), 32'd7);
    drive(0, 40'h00_0000_0000, 40'h00_0000_0000, 1'b0);

    repeat (12) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("queue%0d_drained", k), 32'(q_n[k].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
